// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with single-outstanding data-memory port and MEM/WB register
module mem_stage #(
    parameter int PC_BITS = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        result_e,
    input  logic [31:0]        store_data_e,
    input  logic               wb_sel_e,
    input  logic               write_e,
    input  logic               m_write_e,
    input  logic [4:0]         writeregsel_e,
    input  logic [PC_BITS-1:0] pc_e,
    output logic               stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    output logic [31:0]        wb_data,
    output logic               write_w,
    output logic [4:0]         writeregsel_w,
    output logic [PC_BITS-1:0] pc_w,
    output logic               bus_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 bus_err_q;
    logic [31:0]          wb_data_q, wb_data_d;
    logic                 write_w_q;
    logic [4:0]           writeregsel_w_q;
    logic [PC_BITS-1:0]   pc_w_q;

    logic access, is_store, is_load, in_idle, event_hit, timeout, complete;

    always_comb begin
        access    = wb_sel_e | m_write_e;
        is_store  = m_write_e;
        is_load   = wb_sel_e & ~m_write_e;
        in_idle   = (state_q == S_IDLE);
        // Grant only matters while requesting, rvalid only while awaiting data.
        event_hit = in_idle ? mem_gnt : mem_rvalid;
        // ">=" keeps a load granted in its last allowed cycle bounded in RESP.
        timeout   = access & (cnt_q >= TO_LAST) & ~event_hit;
        complete  = (in_idle & is_store & mem_gnt) | (~in_idle & mem_rvalid) | timeout;
        stall     = access & ~complete;
        mem_req   = in_idle & access;
        mem_we    = in_idle & m_write_e;
        mem_addr  = result_e;
        mem_wdata = store_data_e;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (in_idle) begin
            if (is_load & mem_gnt) begin
                state_d = S_RESP;
            end
        end else if (mem_rvalid) begin
            state_d = S_IDLE;
        end

        cnt_d = cnt_q;
        if (!stall) begin
            cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end

        wb_data_d = result_e;
        if (is_load) begin
            wb_data_d = timeout ? ERR_DATA : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= 8'd0;
            bus_err_q       <= 1'b0;
            wb_data_q       <= 32'd0;
            write_w_q       <= 1'b0;
            writeregsel_w_q <= 5'd0;
            pc_w_q          <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_q | timeout;
            if (stall) begin
                write_w_q <= 1'b0;
            end else begin
                wb_data_q       <= wb_data_d;
                write_w_q       <= write_e & ~m_write_e;
                writeregsel_w_q <= writeregsel_e;
                pc_w_q          <= pc_e;
            end
        end
    end

    assign wb_data       = wb_data_q;
    assign write_w       = write_w_q;
    assign writeregsel_w = writeregsel_w_q;
    assign pc_w          = pc_w_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with transaction-level model
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] result_e, store_data_e, mem_rdata;
    logic        wb_sel_e, write_e, m_write_e, mem_gnt, mem_rvalid;
    logic [4:0]  writeregsel_e;
    logic [15:0] pc_e;
    logic        stall, mem_req, mem_we, write_w, bus_err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [4:0]  writeregsel_w;
    logic [15:0] pc_w;

    mem_stage #(.PC_BITS(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .result_e(result_e), .store_data_e(store_data_e),
        .wb_sel_e(wb_sel_e), .write_e(write_e), .m_write_e(m_write_e),
        .writeregsel_e(writeregsel_e), .pc_e(pc_e),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_data(wb_data), .write_w(write_w), .writeregsel_w(writeregsel_w),
        .pc_w(pc_w), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        wb_sel;
        logic        write;
        logic        m_write;
        logic [4:0]  rd;
        logic [15:0] pc;
        int          g;
        int          r;
    } instr_t;

    int checks = 0;
    int errors = 0;
    int obs_stalls;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [31:0] exp_wb_data;
    logic        exp_write_w, exp_bus_err;
    logic [4:0]  exp_rd;
    logic [15:0] exp_pc;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            if (stall) obs_stalls++;
            cmp("stall", 32'(stall), 32'(exp_stall));
            cmp("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                cmp("mem_we", 32'(mem_we), 32'(exp_we));
                cmp("mem_addr", mem_addr, exp_addr);
                cmp("mem_wdata", mem_wdata, exp_wdata);
            end
            cmp("write_w", 32'(write_w), 32'(exp_write_w));
            cmp("wb_data", wb_data, exp_wb_data);
            cmp("writeregsel_w", 32'(writeregsel_w), 32'(exp_rd));
            cmp("pc_w", 32'(pc_w), 32'(exp_pc));
            cmp("bus_err", 32'(bus_err), 32'(exp_bus_err));
        end
    end

    // Transaction-level view: on which cycle the instruction leaves the stage,
    // whether it left by timeout, and the last cycle the request is presented.
    task automatic plan(input instr_t in, output int k, output bit to, output int req_last);
        if (!(in.wb_sel || in.m_write)) begin
            k = 0; to = 0; req_last = -1;
        end else if (in.m_write) begin
            if (in.g >= 0 && in.g <= TO - 1) begin k = in.g; to = 0; end
            else begin k = TO - 1; to = 1; end
            req_last = k;
        end else if (in.g >= 0 && in.g < TO - 1) begin
            req_last = in.g;
            if (in.r > in.g && in.r <= TO - 1) begin k = in.r; to = 0; end
            else begin k = TO - 1; to = 1; end
        end else begin
            req_last = TO - 1; k = TO - 1; to = 1;
        end
    endtask

    task automatic idle_inputs();
        result_e = 32'd0; store_data_e = 32'd0; wb_sel_e = 1'b0; write_e = 1'b0;
        m_write_e = 1'b0; writeregsel_e = 5'd0; pc_e = 16'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic run(input instr_t in);
        int  k, req_last;
        bit  to;
        bit  load;
        plan(in, k, to, req_last);
        load = in.wb_sel && !in.m_write;
        obs_stalls = 0;
        for (int c = 0; c <= k; c++) begin
            @(negedge clk);
            result_e = in.res; store_data_e = in.sdata; wb_sel_e = in.wb_sel;
            write_e = in.write; m_write_e = in.m_write; writeregsel_e = in.rd; pc_e = in.pc;
            mem_gnt = (c == in.g);
            mem_rvalid = (c == in.r);
            mem_rdata = (c == in.r) ? in.rdata : (32'h0BAD_0000 | 32'(c));
            exp_stall = (c < k);
            exp_req = (c <= req_last);
            exp_we = in.m_write;
            exp_addr = in.res;
            exp_wdata = in.sdata;
            chk_en = 1'b1;
            @(posedge clk); #1;
            if (c < k) begin
                exp_write_w = 1'b0;
            end else begin
                if (load) exp_wb_data = to ? 32'hDEAD_BEEF : in.rdata;
                else      exp_wb_data = in.res;
                exp_write_w = in.write && !in.m_write;
                exp_rd = in.rd;
                exp_pc = in.pc;
                exp_bus_err = exp_bus_err | to;
            end
        end
    endtask

    function automatic instr_t mk(logic [31:0] res, logic [31:0] sdata, logic [31:0] rdata,
                                  logic wb_sel, logic write, logic m_write, logic [4:0] rd,
                                  logic [15:0] pc, int g, int r);
        instr_t t;
        t.res = res; t.sdata = sdata; t.rdata = rdata; t.wb_sel = wb_sel; t.write = write;
        t.m_write = m_write; t.rd = rd; t.pc = pc; t.g = g; t.r = r;
        return t;
    endfunction

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        exp_wb_data = 32'd0; exp_write_w = 1'b0; exp_rd = 5'd0; exp_pc = 16'd0; exp_bus_err = 1'b0;
        #12;
        cmp("rst_wb_data", wb_data, 32'd0);
        cmp("rst_write_w", 32'(write_w), 32'd0);
        cmp("rst_pc_w", 32'(pc_w), 32'd0);
        cmp("rst_bus_err", 32'(bus_err), 32'd0);
        cmp("rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(mk(32'h1234, 32'h0, 32'h0, 0, 1, 0, 5'd7, 16'h0100, -1, -1));
        cmp("alu_lit_wb", wb_data, 32'h0000_1234);
        cmp("alu_lit_write_w", 32'(write_w), 32'd1);
        cmp("alu_lit_rd", 32'(writeregsel_w), 32'd7);

        run(mk(32'h40, 32'hCAFE_F00D, 32'h0, 0, 1, 1, 5'd3, 16'h0104, 2, -1));
        cmp("store_lit_stalls", 32'(obs_stalls), 32'd2);
        cmp("store_lit_write_w", 32'(write_w), 32'd0);

        run(mk(32'h80, 32'h0, 32'hA5A5_A5A5, 1, 1, 0, 5'd5, 16'h0108, 0, 3));
        cmp("load_lit_stalls", 32'(obs_stalls), 32'd3);
        cmp("load_lit_wb", wb_data, 32'hA5A5_A5A5);
        cmp("load_lit_write_w", 32'(write_w), 32'd1);
        cmp("load_lit_bus_err", 32'(bus_err), 32'd0);

        run(mk(32'h44, 32'h1111_2222, 32'h0, 1, 1, 1, 5'd9, 16'h010C, 0, -1));
        cmp("ldst_lit_write_w", 32'(write_w), 32'd0);

        run(mk(32'h90, 32'h0, 32'h0, 1, 1, 0, 5'd6, 16'h0110, 0, -1));
        cmp("tmo_lit_stalls", 32'(obs_stalls), 32'd3);
        cmp("tmo_lit_wb", wb_data, 32'hDEAD_BEEF);
        cmp("tmo_lit_bus_err", 32'(bus_err), 32'd1);

        run(mk(32'h5678, 32'h0, 32'h0, 0, 1, 0, 5'd8, 16'h0114, -1, -1));
        run(mk(32'hA0, 32'h0, 32'h1357_9BDF, 1, 1, 0, 5'd10, 16'h0118, 0, 1));
        run(mk(32'hA4, 32'h0, 32'h2468_ACE0, 1, 1, 0, 5'd11, 16'h011C, 1, 2));
        run(mk(32'hA8, 32'h0, 32'h0, 1, 1, 0, 5'd12, 16'h0120, -1, -1));
        run(mk(32'hAC, 32'h7777_8888, 32'h0, 0, 0, 1, 5'd13, 16'h0124, -1, -1));
        run(mk(32'h9ABC, 32'h0, 32'h0, 0, 1, 0, 5'd14, 16'h0128, -1, -1));
        cmp("sticky_lit_bus_err", 32'(bus_err), 32'd1);

        // Reset in the middle of a load that has been granted and awaits data.
        @(negedge clk);
        chk_en = 1'b0;
        result_e = 32'hC0; wb_sel_e = 1'b1; write_e = 1'b1; writeregsel_e = 5'd15; pc_e = 16'h0130;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        cmp("mid_rst_stall", 32'(stall), 32'd0);
        cmp("mid_rst_mem_req", 32'(mem_req), 32'd0);
        cmp("mid_rst_wb_data", wb_data, 32'd0);
        cmp("mid_rst_write_w", 32'(write_w), 32'd0);
        cmp("mid_rst_rd", 32'(writeregsel_w), 32'd0);
        cmp("mid_rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #2;
        cmp("stray_rvalid_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        cmp("stray_rvalid_write_w", 32'(write_w), 32'd0);
        cmp("stray_rvalid_wb", wb_data, 32'd0);

        exp_wb_data = 32'd0; exp_write_w = 1'b0; exp_rd = 5'd0; exp_pc = 16'd0; exp_bus_err = 1'b0;
        run(mk(32'hB0, 32'h0, 32'h0F0F_0F0F, 1, 1, 0, 5'd16, 16'h0140, 0, 2));
        cmp("post_rst_lit_stalls", 32'(obs_stalls), 32'd2);
        run(mk(32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 16'h0144, -1, -1));
        cmp("post_rst_lit_bus_err", 32'(bus_err), 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits between the execute stage's EX/MEM flops and writeback. It accepts the ALU result, control bits and store data produced by execute. For loads and stores it runs a single-outstanding request/grant/response transaction on the data-memory port, and stalls upstream until the access completes. It then registers the MEM/WB bundle: writeback data, register write enable, destination and PC.

## Interface
Parameters:
- PC_BITS, 16, width of the PC carried down the pipe
- TIMEOUT, 255, maximum cycles an access may wait (grant or response) before being forced complete; 8-bit counter, legal range 1..255

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- result_e  in  32  ALU result from execute; memory byte address for loads/stores
- store_data_e  in  32  store data (register rs2 value)
- wb_sel_e  in  1  1 = load (writeback from memory), 0 = ALU result
- write_e  in  1  register-file write enable
- m_write_e  in  1  store
- writeregsel_e  in  5  destination register
- pc_e  in  PC_BITS  PC from execute
- stall  out  1  combinational; holds all upstream stages while 1
- mem_req  out  1  request valid to data memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  = result_e
- mem_wdata  out  32  = store_data_e
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- wb_data  out  32  MEM/WB writeback data
- write_w  out  1  MEM/WB register write enable
- writeregsel_w  out  5  MEM/WB destination
- pc_w  out  PC_BITS  MEM/WB PC
- bus_err  out  1  sticky timeout flag

## Operation
- access = wb_sel_e | m_write_e.
- If m_write_e and wb_sel_e are both 1, the access is a store. write_w is forced to 0 for that instruction.
- FSM states:
  - IDLE: mem_req = access, mem_we = m_write_e.
    - Store + mem_gnt: complete this cycle and stay in IDLE.
    - Load + mem_gnt: go to RESP.
    - No grant: stay in IDLE, with the request held.
  - RESP: mem_req = 0. On mem_rvalid, the load completes and the FSM returns to IDLE.
- stall = access & ~complete, where complete is one of:
  - IDLE & store & mem_gnt
  - RESP & mem_rvalid
  - timeout
- While a request is pending and ungranted, mem_req, mem_addr, mem_wdata and mem_we are held stable. The upstream inputs are held by stall.
- mem_rvalid is ignored in IDLE. mem_gnt is ignored in RESP.
- Timeout counter:
  - Cleared in any cycle where stall = 0.
  - Increments each stalled cycle.
  - When the counter equals TIMEOUT-1 and there is no gnt/rvalid that cycle, the access completes anyway:
    - Load: wb_data = 32'hDEAD_BEEF, write_w = write_e.
    - Store: dropped.
  - A timeout sets bus_err and returns the FSM to IDLE.
  - gnt/rvalid arriving in the timeout cycle wins; bus_err is not set.
- bus_err is cleared only by reset.
- MEM/WB register update:
  - When stall = 0: wb_data <= (load ? mem_rdata : result_e), write_w <= write_e & ~m_write_e, writeregsel_w <= writeregsel_e, pc_w <= pc_e.
  - When stall = 1: write_w <= 0 (bubble). Other MEM/WB regs hold.

## Timing
- Reset values:
  - state = IDLE, counter = 0, bus_err = 0
  - wb_data = 0, write_w = 0, writeregsel_w = 0, pc_w = 0
  - mem_req is combinational and therefore 0 while in reset if access is 0. In IDLE it follows access.
- Reset mid-access: the FSM returns to IDLE immediately. A later stray mem_rvalid is ignored.
- Non-memory op: 0 stall cycles; MEM/WB valid 1 edge after the inputs.
- Store with same-cycle grant: 0 stall cycles.
- Load, grant in cycle 0, rvalid in cycle N (N ≥ 1):
  - stall = 1 for cycles 0..N-1.
  - wb_data = mem_rdata is captured at the end of cycle N.
- Back-to-back accesses: a new request may be issued in the cycle immediately after completion. At most one transaction is outstanding.

## Test plan
- ALU op (result_e=0x1234, write_e=1, writeregsel_e=7, wb_sel_e=0, m_write_e=0) -> mem_req=0, stall=0; next edge: wb_data=0x1234, write_w=1, writeregsel_w=7.
- Store (m_write_e=1, addr 0x40, data 0xCAFEF00D), mem_gnt low for 2 cycles then high -> mem_req=1 with stable addr/data for 3 cycles, stall=1,1,0, write_w=0 throughout.
- Load (wb_sel_e=1, write_e=1, addr 0x80), gnt in cycle 0, rvalid with 0xA5A5A5A5 in cycle 3 -> stall high cycles 0–2, write_w=0 during the stall, then wb_data=0xA5A5A5A5 and write_w=1.
- Load whose rvalid never arrives, TIMEOUT=4 -> stall for 3 cycles, then wb_data=0xDEADBEEF and bus_err=1, which persists through subsequent accesses.
- wb_sel_e=1 with m_write_e=1 -> treated as a store (mem_we=1), write_w=0.
- Reset asserted in RESP, then mem_rvalid pulses after release -> outputs at reset values; the rvalid causes no writeback and the FSM stays in IDLE.
